// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Shares one memory bus between the CPU fetch and data ports,
//               data-first with a starvation guard for pending fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch port
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // data-access port
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // memory bus
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  // status
  output logic        owner,
  output logic        busy
);

  localparam int            SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [SW-1:0] streak;
  logic          op_write;
  logic          fetch_req;
  logic          data_req;
  logic          grant;
  logic          grant_data;

  // Data wins a tie unless the fetch port has been passed over STARVE_LIMIT times.
  always_comb begin
    fetch_req  = i_read;
    data_req   = d_read | d_write;
    grant      = (state == IDLE) && (fetch_req || data_req);
    grant_data = data_req && !(fetch_req && (streak == LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = BUS;
      BUS:     if (!m_waitrequest) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_read        = (state == BUS) && !op_write;
    m_write       = (state == BUS) && op_write;
    busy          = (state != IDLE);
    i_waitrequest = !((state == ACK) && !owner);
    d_waitrequest = !((state == ACK) && owner);
    i_readdata    = ((state == ACK) && !owner) ? m_readdata : 32'h0;
    d_readdata    = ((state == ACK) && owner && !op_write) ? m_readdata : 32'h0;
  end

  // Request copies are captured only at grant, so a withdrawn request still completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner        <= 1'b0;
      op_write     <= 1'b0;
      m_address    <= 32'h0;
      m_writedata  <= 32'h0;
      m_byteenable <= 4'h0;
      streak       <= '0;
    end else if (grant) begin
      owner        <= grant_data;
      op_write     <= grant_data && d_write;
      m_address    <= grant_data ? d_address : i_address;
      m_writedata  <= grant_data ? d_writedata : 32'h0;
      m_byteenable <= grant_data ? d_byteenable : 4'hF;
      if (grant_data && fetch_req) begin
        streak <= (streak == LIMIT) ? streak : streak + 1'b1;
      end else begin
        streak <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single memory bus (address/read/write/waitrequest/writedata/byteenable/readdata) between the CPU instruction-fetch port and data-access port.
- Sits between the mips_cpu_bus core internals and the external memory slave.
- Serialises one transaction at a time and absorbs the memory's one-cycle registered read latency.
- Applies fixed data-over-fetch priority with a starvation guard.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending; the next grant then goes to fetch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_address  input  32  fetch byte address.
- i_read  input  1  fetch read request.
- i_waitrequest  output  1  fetch stall; low for exactly the completion cycle.
- i_readdata  output  32  fetch data; valid when i_waitrequest=0.
- d_address  input  32  data byte address.
- d_read  input  1  data read request.
- d_write  input  1  data write request.
- d_writedata  input  32  store data.
- d_byteenable  input  4  store/load byte lanes.
- d_waitrequest  output  1  data stall; low for exactly the completion cycle.
- d_readdata  output  32  load data; valid when d_waitrequest=0.
- m_address  output  32  bus address.
- m_read  output  1  bus read.
- m_write  output  1  bus write.
- m_writedata  output  32  bus write data.
- m_byteenable  output  4  bus lanes.
- m_waitrequest  input  1  slave stall.
- m_readdata  input  32  slave read data, registered one cycle after an accepted read.
- owner  output  1  current grant: 0=fetch, 1=data.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. On reset:
  - state=IDLE, m_read=0, m_write=0, m_address=0, m_writedata=0, m_byteenable=0.
  - i_waitrequest=1, d_waitrequest=1, i_readdata=0, d_readdata=0.
  - owner=0, busy=0, streak=0.
- States: IDLE, BUS, ACK.
- IDLE:
  - Grant on a clk edge if i_read or (d_read|d_write) is high.
  - Latch the owner's address, writedata and byteenable (fetch uses 4'b1111), plus the operation type. Then go to BUS.
  - With no request, stay in IDLE.
- Grant rule:
  - Only data pending: grant data.
  - Only fetch pending: grant fetch.
  - Both pending: grant data unless streak==STARVE_LIMIT, in which case grant fetch.
- Streak counter:
  - Increments on a data grant made while i_read is high.
  - Clears on a fetch grant, or on a data grant made with i_read low.
  - Saturates at STARVE_LIMIT.
- BUS:
  - m_read or m_write is high, driven from the latched copies. The latched copies stay stable while m_waitrequest=1.
  - Transfer is accepted at the edge where m_waitrequest=0. Then go to ACK, and drop m_read/m_write in the same edge.
- ACK (exactly 1 cycle):
  - Owner's waitrequest=0. For a read, owner readdata = m_readdata (combinational pass-through; valid this cycle).
  - Next state is IDLE.
  - Minimum latency is 3 cycles from request to completion: IDLE, BUS, ACK.
- Waitrequest outside ACK: both requester waitrequests are 1 at all other times, whether or not the port is requesting.
- Requester obligations:
  - Hold request and signals stable while its waitrequest=1.
  - A request withdrawn mid-BUS is ignored. The bus transaction completes from the latched copy and ACK is still issued.
- d_read and d_write both high: treated as a write; the read is dropped.
- Back-to-back transactions: a new grant cannot occur until the IDLE following ACK. A requester that keeps its request high after its ACK is re-arbitrated as a new transaction.
- Reset mid-operation: asynchronous. m_read/m_write fall immediately, the transaction is abandoned and no ACK is issued.
- Widths: addresses are passed unmodified as byte addresses; the arbiter performs no address mapping.

Test Plan:
- Single fetch: i_read=1, i_address=BFC00000, memory word 3C08BFC0, m_waitrequest=0.
  - Required: m_read high 1 cycle, m_byteenable=1111.
  - i_waitrequest=0 on the 3rd cycle after request, with i_readdata=3C08BFC0.
- Stalled store: d_write=1, d_address=BFC00030, d_writedata=0000000F, d_byteenable=0001, m_waitrequest high 3 cycles.
  - Required: m_write held 4 cycles with address/data/byteenable stable.
  - d_waitrequest=0 for exactly 1 cycle after acceptance; owner=1.
- Contention: i_read and d_read asserted in the same cycle.
  - Required: data transaction completes first, then fetch.
  - owner sequence 1 then 0; each readdata delivered only to its owner.
- Starvation, STARVE_LIMIT=4: d_read held continuously with i_read high.
  - Required: grants 1-4 go to data, grant 5 goes to fetch, grant 6 goes back to data.
- Reset during BUS with m_waitrequest=1:
  - Required: m_read=0 and busy=0 before the next clk edge, no waitrequest low pulse, state IDLE.
- Illegal combination: d_read=1 and d_write=1.
  - Required: m_write=1 and m_read=0 for the transaction; d_waitrequest low pulse occurs once.
